// File: rtl/tm_ctrl.sv
// tm_ctrl: Turing-machine sequencer in front of the tape cache.
// Each step latches the symbol under the head, matches (machine state, symbol)
// against a 2**RULE_BITS entry rule table (lowest index wins), and then halts,
// faults, or issues one move/move_done handshake to the tape.
//
// Optional build macro: TM_CTRL_SINGLE_STEP_EN adds step_i. In that build
// FETCH waits for a step_i pulse, seen at or after tape_valid_i, before LOOKUP.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start_i / stop_i           run control pulses
//   step_i                     single-step pulse (TM_CTRL_SINGLE_STEP_EN only)
//   prog_we_i/idx_i/data_i     rule write port, accepted only while idle
//   tape_data_i/valid_i        symbol under the head
//   move_o/dir_o/data_o        move request to the tape; move_done_i completes it
//   busy_o, halted_o, fault_o  run status
//   mstate_o, steps_o          machine state and saturating completed-move count
module tm_ctrl #(
    parameter  int unsigned STATE_BITS = 4,
    parameter  int unsigned RULE_BITS  = 4,
    localparam int unsigned RULE_W     = 2 * STATE_BITS + 19
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  stop_i,
`ifdef TM_CTRL_SINGLE_STEP_EN
    input  logic                  step_i,
`endif
    input  logic                  prog_we_i,
    input  logic [RULE_BITS-1:0]  prog_idx_i,
    input  logic [RULE_W-1:0]     prog_data_i,
    input  logic [7:0]            tape_data_i,
    input  logic                  tape_valid_i,
    output logic                  move_o,
    output logic                  move_dir_o,
    output logic [7:0]            move_data_o,
    input  logic                  move_done_i,
    output logic                  busy_o,
    output logic                  halted_o,
    output logic                  fault_o,
    output logic [STATE_BITS-1:0] mstate_o,
    output logic [15:0]           steps_o
);

    localparam int unsigned RULE_N = 1 << RULE_BITS;

    typedef struct packed {
        logic                  en;
        logic                  halt;
        logic                  dir;
        logic [7:0]            wr_sym;
        logic [STATE_BITS-1:0] nxt_state;
        logic [7:0]            match_sym;
        logic [STATE_BITS-1:0] cur_state;
    } rule_t;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOOKUP, S_MOVE, S_HALT, S_FAULT
    } ctrl_t;

    ctrl_t                 state_q, state_d;
    rule_t                 rules_q [RULE_N];
    logic [STATE_BITS-1:0] mstate_q;
    logic [STATE_BITS-1:0] nxt_q;
    logic [7:0]            sym_q;
    logic [15:0]           steps_q;
    logic                  stop_pend_q, stop_pend_d;
    logic                  busy;
    logic                  fetch_go;

    logic                  hit;
    logic                  hit_halt;
    logic                  hit_dir;
    logic [7:0]            hit_wr;
    logic [STATE_BITS-1:0] hit_nxt;

    logic ld_sym, ld_move, ld_halt, commit, clr_run;

    assign busy = (state_q == S_FETCH) || (state_q == S_LOOKUP) || (state_q == S_MOVE);

`ifdef TM_CTRL_SINGLE_STEP_EN
    assign fetch_go = tape_valid_i & step_i;
`else
    assign fetch_go = tape_valid_i;
`endif

    // Priority match: scan downward so the lowest matching index is kept.
    always_comb begin
        hit      = 1'b0;
        hit_halt = 1'b0;
        hit_dir  = 1'b0;
        hit_wr   = 8'h00;
        hit_nxt  = '0;
        for (int i = int'(RULE_N) - 1; i >= 0; i--) begin
            if (rules_q[i].en && (rules_q[i].cur_state == mstate_q) &&
                (rules_q[i].match_sym == sym_q)) begin
                hit      = 1'b1;
                hit_halt = rules_q[i].halt;
                hit_dir  = rules_q[i].dir;
                hit_wr   = rules_q[i].wr_sym;
                hit_nxt  = rules_q[i].nxt_state;
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and datapath strobes; stop wins over start only while busy.
    always_comb begin
        state_d     = state_q;
        stop_pend_d = 1'b0;
        ld_sym      = 1'b0;
        ld_move     = 1'b0;
        ld_halt     = 1'b0;
        commit      = 1'b0;
        clr_run     = 1'b0;
        case (state_q)
            S_IDLE, S_HALT, S_FAULT: begin
                if (start_i) begin
                    state_d = S_FETCH;
                    clr_run = 1'b1;
                end
            end
            S_FETCH: begin
                if (stop_i) begin
                    state_d = S_HALT;
                end else if (fetch_go) begin
                    state_d = S_LOOKUP;
                    ld_sym  = 1'b1;
                end
            end
            S_LOOKUP: begin
                if (stop_i) begin
                    state_d = S_HALT;
                end else if (!hit) begin
                    state_d = S_FAULT;
                end else if (hit_halt) begin
                    state_d = S_HALT;
                    ld_halt = 1'b1;
                end else begin
                    state_d = S_MOVE;
                    ld_move = 1'b1;
                end
            end
            S_MOVE: begin
                // A move in flight always completes; stop only redirects the exit.
                if (move_done_i) begin
                    commit  = 1'b1;
                    state_d = (stop_i || stop_pend_q) ? S_HALT : S_FETCH;
                end else begin
                    stop_pend_d = stop_pend_q | stop_i;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Machine datapath and rule table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstate_q    <= '0;
            nxt_q       <= '0;
            sym_q       <= 8'h00;
            steps_q     <= 16'h0000;
            stop_pend_q <= 1'b0;
            move_dir_o  <= 1'b0;
            move_data_o <= 8'h00;
            for (int i = 0; i < int'(RULE_N); i++) rules_q[i] <= '0;
        end else begin
            stop_pend_q <= stop_pend_d;
            if (ld_sym) sym_q <= tape_data_i;
            if (ld_move) begin
                nxt_q       <= hit_nxt;
                move_dir_o  <= hit_dir;
                move_data_o <= hit_wr;
            end
            if (clr_run) begin
                mstate_q <= '0;
                steps_q  <= 16'h0000;
            end else if (ld_halt) begin
                mstate_q <= hit_nxt;
            end else if (commit) begin
                mstate_q <= nxt_q;
                if (steps_q != 16'hFFFF) steps_q <= steps_q + 16'd1;
            end
            if (prog_we_i && !busy) rules_q[prog_idx_i] <= rule_t'(prog_data_i);
        end
    end

    assign move_o   = (state_q == S_MOVE);
    assign busy_o   = busy;
    assign halted_o = (state_q == S_HALT) || (state_q == S_FAULT);
    assign fault_o  = (state_q == S_FAULT);
    assign mstate_o = mstate_q;
    assign steps_o  = steps_q;

endmodule

// File: tb/tb_tm_ctrl.sv
// Testbench for tm_ctrl: directed scenarios plus randomized rule tables, all
// checked against a behavioural Turing-machine interpreter and a tape model.
module tb_tm_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i, stop_main, stop_auto, stop_i;
    logic        step_i;
    logic        prog_we;
    logic [3:0]  prog_idx;
    logic [26:0] prog_data;
    logic [7:0]  tape_data;
    logic        tape_valid;
    logic        move_o, move_dir;
    logic [7:0]  move_data;
    logic        done;
    logic        busy, halted, fault;
    logic [3:0]  mstate;
    logic [15:0] steps;

    always #5 clk = ~clk;

    assign stop_i = stop_main | stop_auto;

    tm_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .stop_i       (stop_i),
`ifdef TM_CTRL_SINGLE_STEP_EN
        .step_i       (step_i),
`endif
        .prog_we_i    (prog_we),
        .prog_idx_i   (prog_idx),
        .prog_data_i  (prog_data),
        .tape_data_i  (tape_data),
        .tape_valid_i (tape_valid),
        .move_o       (move_o),
        .move_dir_o   (move_dir),
        .move_data_o  (move_data),
        .move_done_i  (done),
        .busy_o       (busy),
        .halted_o     (halted),
        .fault_o      (fault),
        .mstate_o     (mstate),
        .steps_o      (steps)
    );

    // Tape environment
    logic [7:0] tape [256];
    logic [7:0] head;
    int         lat, stop_at, lat_cnt;
    int         req_cnt, req_base;
    logic       last_dir;
    logic [7:0] last_data, first_data;

    assign tape_data = tape[head];

    // Reference rule table and interpreter state
    bit         r_en [16], r_halt [16], r_dir [16];
    int         r_wr [16], r_nxt [16], r_ms [16], r_cs [16];
    logic [7:0] mtape [256];
    int         e_state, e_steps, e_head;
    bit         e_fault;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;
    bit seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Tape responder: counts move requests, completes each after lat cycles.
    task automatic responder();
        forever begin
            @(posedge clk); #1;
            stop_auto = 1'b0;
            if (done) begin
                done = 1'b0;
            end else if (move_o) begin
                if (lat_cnt == 0) begin
                    req_cnt++;
                    last_dir  = move_dir;
                    last_data = move_data;
                    if (req_cnt - req_base == 1) first_data = move_data;
                    if (stop_at > 0 && req_cnt - req_base == stop_at) stop_auto = 1'b1;
                end
                if (lat_cnt >= lat) begin
                    tape[head] = move_data;
                    head       = move_dir ? head + 8'd1 : head - 8'd1;
                    done       = 1'b1;
                    lat_cnt    = 0;
                end else begin
                    lat_cnt++;
                end
            end
        end
    endtask

    // Interpret the rule table directly on a copy of the tape.
    task automatic model_run(input int stop_v);
        int ms, st, h, it, hit;
        bit fin;
        ms = 0; st = 0; h = 128; it = 0; fin = 0;
        e_fault = 0;
        while (!fin && it < 10000) begin
            it++;
            hit = -1;
            for (int i = 15; i >= 0; i--)
                if (r_en[i] && r_cs[i] == ms && r_ms[i] == int'(mtape[h])) hit = i;
            if (hit < 0) begin
                e_fault = 1; fin = 1;
            end else if (r_halt[hit]) begin
                ms = r_nxt[hit]; fin = 1;
            end else begin
                mtape[h] = 8'(r_wr[hit]);
                h  = r_dir[hit] ? (h + 1) % 256 : (h + 255) % 256;
                ms = r_nxt[hit];
                st++;
                if (stop_v > 0 && st == stop_v) fin = 1;
            end
        end
        e_state = ms; e_steps = st; e_head = h;
    endtask

    task automatic prog(input int idx, input bit en, input bit h, input bit d, input int wr,
                        input int nx, input int ms, input int cs, input bit upd);
        prog_idx  = 4'(idx);
        prog_data = {en, h, d, 8'(wr), 4'(nx), 8'(ms), 4'(cs)};
        prog_we   = 1'b1;
        @(posedge clk); #1;
        prog_we   = 1'b0;
        if (upd) begin
            r_en[idx] = en; r_halt[idx] = h; r_dir[idx] = d;
            r_wr[idx] = wr; r_nxt[idx] = nx; r_ms[idx] = ms; r_cs[idx] = cs;
        end
    endtask

    task automatic clear_rules();
        for (int i = 0; i < 16; i++) prog(i, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic fill_tape(input int v);
        for (int i = 0; i < 256; i++) tape[i] = 8'(v);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic begin_run(input int stop_v, input int lat_v);
        head = 8'd128;
        for (int i = 0; i < 256; i++) mtape[i] = tape[i];
        model_run(stop_v);
        lat      = lat_v;
        stop_at  = stop_v;
        lat_cnt  = 0;
        req_base = req_cnt;
        pulse_start();
    endtask

    task automatic finish_run(input string tag);
        int diffs;
        cyc = 0;
        while (!halted && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_halted"}, halted, 1);
        chk({tag, "_fault"},  fault, e_fault);
        chk({tag, "_busy"},   busy, 0);
        chk({tag, "_mstate"}, mstate, e_state);
        chk({tag, "_steps"},  steps, e_steps);
        chk({tag, "_moves"},  req_cnt - req_base, e_steps);
        chk({tag, "_head"},   head, e_head);
        diffs = 0;
        for (int i = 0; i < 256; i++) if (tape[i] !== mtape[i]) diffs++;
        chk({tag, "_tape"}, diffs, 0);
    endtask

    initial begin
        rst_n = 1'b0; start_i = 1'b0; stop_main = 1'b0; stop_auto = 1'b0;
        step_i = 1'b1; prog_we = 1'b0; prog_idx = 4'h0; prog_data = '0;
        tape_valid = 1'b1; done = 1'b0; head = 8'd128;
        lat = 0; stop_at = 0; lat_cnt = 0; req_cnt = 0; req_base = 0;
        last_dir = 1'b0; last_data = 8'h00; first_data = 8'h00;
        for (int i = 0; i < 16; i++) begin
            r_en[i] = 0; r_halt[i] = 0; r_dir[i] = 0;
            r_wr[i] = 0; r_nxt[i] = 0; r_ms[i] = 0; r_cs[i] = 0;
        end
        fill_tape(0);
        fork responder(); join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {move_o, move_dir, move_data, busy, halted, fault, mstate, steps}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Empty table: fault within three cycles of start, no move
        fill_tape(0);
        begin_run(0, 0);
        cyc = 0;
        while (!halted && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("fault_latency", (cyc <= 2), 1);
        finish_run("empty");
        chk("empty_fault_flag", fault, 1);

        // Write-right-then-halt program
        prog(0, 1, 0, 1, 8'h01, 1, 8'h00, 0, 1);
        prog(1, 1, 1, 0, 0, 2, 8'h00, 1, 1);
        fill_tape(0);
        begin_run(0, 1);
        finish_run("two_rule");
        chk("two_rule_dir", last_dir, 1);
        chk("two_rule_data", last_data, 8'h01);
        chk("two_rule_steps", steps, 1);
        chk("two_rule_mstate", mstate, 2);

        // Duplicate matches: lowest index wins
        clear_rules();
        prog(7, 1, 0, 0, 8'h77, 6, 8'h41, 0, 1);
        prog(3, 1, 0, 1, 8'h33, 5, 8'h41, 0, 1);
        fill_tape(8'h41);
        begin_run(0, 0);
        finish_run("prio");
        chk("prio_data", first_data, 8'h33);

        // stop_i during a slow move: move held until done, then HALT
        clear_rules();
        prog(0, 1, 0, 1, 8'h02, 0, 8'h00, 0, 1);
        fill_tape(0);
        head = 8'd128; lat = 5; stop_at = 0; lat_cnt = 0; req_base = req_cnt;
        pulse_start();
        cyc = 0;
        while (!move_o && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("stop_move_seen", move_o, 1);
        stop_main = 1'b1;
        @(posedge clk); #1;
        stop_main = 1'b0;
        chk("stop_move_held", move_o, 1);
        cyc = 0;
        while (!halted && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("stop_halted", halted, 1);
        chk("stop_fault", fault, 0);
        chk("stop_steps", steps, 1);
        chk("stop_tape", tape[128], 8'h02);
        repeat (10) @(posedge clk);
        #1;
        chk("stop_no_more_moves", req_cnt - req_base, 1);
        chk("stop_move_low", move_o, 0);

        // Rule writes ignored while busy, applied after HALT
        clear_rules();
        prog(0, 1, 0, 1, 8'h05, 1, 8'h00, 0, 1);
        prog(1, 1, 0, 1, 8'h06, 2, 8'h00, 1, 1);
        prog(2, 1, 1, 0, 0, 3, 8'h00, 2, 1);
        fill_tape(0);
        begin_run(0, 2);
        chk("busy_write_busy", busy, 1);
        prog(0, 1, 1, 0, 0, 9, 8'h00, 0, 0);
        finish_run("busy_write");
        prog(0, 1, 1, 0, 0, 9, 8'h00, 0, 1);
        fill_tape(0);
        begin_run(0, 0);
        finish_run("idle_write");
        chk("idle_write_mstate", mstate, 9);

        // tape_valid_i low holds FETCH; move two cycles after valid
        clear_rules();
        prog(0, 1, 0, 1, 8'h01, 1, 8'h00, 0, 1);
        prog(1, 1, 1, 0, 0, 2, 8'h00, 1, 1);
        fill_tape(0);
        tape_valid = 1'b0;
        begin_run(0, 0);
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (move_o || !busy) seen = 1;
        end
        chk("valid_low_stall", seen, 0);
        tape_valid = 1'b1;
        @(posedge clk); #1;
        chk("valid_plus1", move_o, 0);
        @(posedge clk); #1;
        chk("valid_plus2", move_o, 1);
        finish_run("valid");

        // Randomized tables on a small alphabet, stopped after a random move count
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 16; i++)
                prog(i, ($urandom % 4) != 0, ($urandom % 6) == 0, 1'($urandom % 2),
                     int'($urandom % 4), int'($urandom % 4), int'($urandom % 4),
                     int'($urandom % 4), 1);
            for (int i = 0; i < 256; i++) tape[i] = 8'($urandom % 4);
            begin_run(1 + int'($urandom % 25), int'($urandom % 4));
            finish_run($sformatf("rand%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tm_ctrl.md
Name: tm_ctrl

Overview:
- Turing-machine sequencer; sits directly upstream of the tape cache.
- Each step: reads the current tape symbol and its valid flag, matches (machine state, symbol) against a programmable rule table, then issues a one-cell move with a write symbol and direction.
- Handshakes with the tape's move/move_done interface; reports halt, fault and a step count to the top level.

Parameters:
- STATE_BITS, 4, width of machine state register.
- RULE_BITS, 4, log2 of rule-table depth (16 rules).
- RULE_W, 2*STATE_BITS+19, packed rule width (derived localparam).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start_i  in  1  pulse; begin execution from state 0
- stop_i  in  1  pulse; request halt
- prog_we_i  in  1  rule write strobe
- prog_idx_i  in  RULE_BITS  rule index
- prog_data_i  in  RULE_W  packed rule {en, halt, dir, wr_sym[7:0], nxt_state, match_sym[7:0], cur_state}, with cur_state in the LSBs
- tape_data_i  in  8  symbol under head
- tape_valid_i  in  1  tape_data_i is valid
- move_o  out  1  move request to tape
- move_dir_o  out  1  1 = right, 0 = left
- move_data_o  out  8  symbol written at the current cell
- move_done_i  in  1  tape move complete, one-cycle pulse
- busy_o  out  1  running, i.e. ctrl state not in {IDLE, HALT, FAULT}
- halted_o  out  1  in HALT or FAULT
- fault_o  out  1  no rule matched
- mstate_o  out  STATE_BITS  current machine state
- steps_o  out  16  completed moves, saturating

Behaviour:
- Reset values:
  - ctrl state = IDLE; mstate = 0; steps = 0.
  - All outputs 0.
  - All rule en bits cleared.
- Ctrl states: IDLE, FETCH, LOOKUP, MOVE, HALT, FAULT.
- IDLE:
  - start_i -> FETCH, with mstate <= 0 and steps <= 0.
  - Same transition from HALT and FAULT; start_i also clears fault_o.
- FETCH:
  - Wait for tape_valid_i = 1.
  - Then register tape_data_i -> LOOKUP.
- LOOKUP (one cycle):
  - Parallel compare of all rules with en = 1, cur_state == mstate and match_sym == latched symbol.
  - Lowest matching index wins.
  - No match -> FAULT, fault_o = 1.
  - Match with halt = 1 -> HALT, mstate <= nxt_state, no tape move.
  - Match with halt = 0:
    - Latch dir, wr_sym, nxt_state.
    - move_dir_o / move_data_o <= latched values -> MOVE.
- MOVE:
  - move_o = 1, decoded from ctrl state == MOVE.
  - On move_done_i: mstate <= nxt_state, steps <= steps + 1 (stays at 16'hFFFF), -> FETCH.
  - move_o therefore drops in the cycle after move_done_i. The tape must never see a second move.
- move_dir_o / move_data_o hold stable from LOOKUP exit until the next LOOKUP match. The tape samples dir during its done cycle.
- stop_i:
  - In FETCH or LOOKUP: -> HALT next cycle.
  - In MOVE: registered as pending; honoured on move_done_i, going to HALT instead of FETCH. An in-flight move is never aborted.
  - Ignored in IDLE, HALT, FAULT.
- Simultaneous start_i and stop_i: stop wins when busy, start wins when not busy.
- prog_we_i:
  - Writes rule[prog_idx_i] only when busy_o = 0; ignored while busy.
  - A write takes effect for the next LOOKUP.
- Rule width: the packed fields are exact; no sign extension. State compare is STATE_BITS wide.
- tape_valid_i deasserting during LOOKUP/MOVE is ignored, because the symbol is latched.
- Async reset mid-MOVE: move_o drops immediately. The tape is reset by the same rst_n.

Optional Feature:
- Macro TM_CTRL_SINGLE_STEP_EN.
- Defined:
  - Adds input step_i (1 bit).
  - FETCH additionally requires a step_i pulse, seen at or after tape_valid_i, before entering LOOKUP.
  - One rule is executed per pulse; pulses outside FETCH are dropped.
  - stop_i is still honoured while waiting.
- Undefined: step_i port absent; FETCH proceeds as soon as tape_valid_i = 1.

Test Plan:
- Reset, then start_i with no rules programmed, tape_valid_i = 1, symbol 0x00 -> FAULT within 3 cycles; fault_o = 1, halted_o = 1, steps_o = 0, move_o never asserted.
- Rule0 {st0, 0x00 -> wr 0x01, R, nxt 1}, Rule1 {st1, 0x00 -> halt, nxt 2}; tape model with done 1 cycle after move -> exactly one move_o pulse (dir = 1, data = 0x01); steps_o = 1, mstate_o = 2, HALT.
- Two rules both matching (st0, 0x41) at idx 3 and idx 7 -> idx 3 action used (check move_data_o matches rule 3's wr_sym).
- stop_i asserted while move_o = 1 with done delayed 5 cycles -> move_o held until done; then HALT; steps_o incremented by 1; no further move.
- prog_we_i pulsed while busy_o = 1 to overwrite the active rule -> table unchanged (behaviour identical to unmodified run); same write after HALT -> new rule applied on next start_i.
- tape_valid_i held low 20 cycles in FETCH -> no LOOKUP, move_o = 0; valid high -> move_o rises 2 cycles later. With TM_CTRL_SINGLE_STEP_EN defined: no move until step_i pulse, then one move per pulse.
